seq_divider: RTL and testbench

Iterative unsigned restoring divider, the inverse of the lab's 4x4 array multiplier. It divides a 2·WIDTH-bit dividend (the multiplier's product width) by a WIDTH-bit divisor, producing one quotient bit per clock. Control is a start/busy/done handshake, so the block can sit behind the multiplier or be driven directly from switches/registers in the lab top level.

---
 rtl/seq_divider_pkg.sv | 16 +
 rtl/seq_divider_div_step.sv | 28 ++
 rtl/seq_divider.sv | 112 +++++++++++
 tb/tb_seq_divider.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the iterative restoring divider.
package seq_divider_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    localparam int WIDTH_DEF = 4;
    localparam int CNT_W     = $clog2(2 * WIDTH_DEF + 1);

    function automatic int cnt_width(input int w);
        return $clog2(2 * w + 1);
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);

    logic [WIDTH:0] trial;
    logic           unused_rem_msb;

    // The running remainder is always below the divisor, so its top bit is never set.
    assign unused_rem_msb = rem_i[WIDTH];
    assign trial          = {rem_i[WIDTH-1:0], bit_i};

    always_comb begin
        rem_o = trial;
        q_o   = 1'b0;
        if (trial >= {1'b0, divisor_i}) begin
            rem_o = trial - {1'b0, divisor_i};
            q_o   = 1'b1;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, one quotient bit per clock.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero
);

    localparam int DW = 2 * WIDTH;
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic            done_q;
    logic            dbz_q;
    logic [DW-1:0]   quo_q;
    logic [WIDTH-1:0] rmd_q;

    // Dividend bits leave at the MSB while quotient bits enter at the LSB of the same register.
    logic [DW-1:0]    dvd_q;
    logic [DW-1:0]    dvd_d;
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH:0]   rem_d;
    logic             qbit_d;
    logic             accept;

    assign accept = (state_q == IDLE) && start && (divisor != '0);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[DW-1]),
        .divisor_i (dsr_q),
        .rem_o     (rem_d),
        .q_o       (qbit_d)
    );

    assign dvd_d = {dvd_q[DW-2:0], qbit_d};

    always_ff @(posedge clk) begin
        if (accept) begin
            dvd_q <= dividend;
            dsr_q <= divisor;
            rem_q <= '0;
        end else if (state_q == CALC) begin
            dvd_q <= dvd_d;
            rem_q <= rem_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            done_q <= 1'b1;
                            dbz_q  <= 1'b1;
                            quo_q  <= '1;
                            rmd_q  <= '0;
                        end else begin
                            state_q <= CALC;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (cnt_q == LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        dbz_q   <= 1'b0;
                        quo_q   <= dvd_d;
                        rmd_q   <= rem_d[WIDTH-1:0];
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive checks of seq_divider at WIDTH=4.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int total = 0;
    int bad   = 0;

    seq_divider #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       dbz;
        int         lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic start_op(input logic [7:0] a, input logic [3:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
    endtask

    // Called 1 time unit after the accept edge; counts edges until done is seen.
    task automatic wait_done(input string nm, input logic [7:0] eq, input logic [3:0] er,
                             input logic edbz, input int elat, input int inj);
        int lat = 0;
        bit busy_ok = 1'b1;
        while (!done && lat < 20) begin
            if (busy !== (elat != 0)) busy_ok = 1'b0;
            if (lat == inj) begin
                start    = 1'b1;
                dividend = 8'd50;
                divisor  = 4'd5;
            end else if (lat == inj + 1) begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, ".latency"}, lat, elat);
        chk({nm, ".done"}, {31'd0, done}, 32'd1);
        chk({nm, ".quotient"}, {24'd0, quotient}, {24'd0, eq});
        chk({nm, ".remainder"}, {28'd0, remainder}, {28'd0, er});
        chk({nm, ".div_by_zero"}, {31'd0, div_by_zero}, {31'd0, edbz});
        chk({nm, ".busy_during"}, {31'd0, busy_ok}, 32'd1);
        chk({nm, ".busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        vec_t vecs[7];
        bit   seen_done;

        vecs[0] = '{8'd200, 4'd7,  8'd28,  4'd4, 1'b0, 8};
        vecs[1] = '{8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 8};
        vecs[2] = '{8'd0,   4'd5,  8'd0,   4'd0, 1'b0, 8};
        vecs[3] = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0, 8};
        vecs[4] = '{8'd37,  4'd0,  8'hFF,  4'd0, 1'b1, 0};
        vecs[5] = '{8'd9,   4'd3,  8'd3,   4'd0, 1'b0, 8};
        vecs[6] = '{8'd250, 4'd11, 8'd22,  4'd8, 1'b0, 8};

        rst      = 1'b1;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.outputs", {17'd0, busy, done, quotient, remainder, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            wait_done($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].lat, -1);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.done_pulse", i), {31'd0, done}, 32'd0);
        end

        // Start during CALC must be ignored; a start held in the done cycle must launch.
        start_op(8'd100, 4'd9);
        wait_done("ignore_mid", 8'd11, 4'd1, 1'b0, 8, 4);
        start    = 1'b1;
        dividend = 8'd15;
        divisor  = 4'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("start_in_done", 8'd3, 4'd3, 1'b0, 8, -1);

        // Asynchronous reset mid-operation aborts without a done.
        start_op(8'd123, 4'd4);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid.outputs", {17'd0, busy, done, quotient, remainder, div_by_zero}, 32'd0);
        seen_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
            if (c == 1) rst = 1'b0;
        end
        chk("rst_mid.no_done", {31'd0, seen_done}, 32'd0);
        start_op(8'd123, 4'd4);
        wait_done("rst_rerun", 8'd30, 4'd3, 1'b0, 8, -1);

        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                start_op(8'(a), 4'(b));
                if (b == 0) begin
                    wait_done($sformatf("sweep%0d/0", a), 8'hFF, 4'd0, 1'b1, 0, -1);
                end else begin
                    wait_done($sformatf("sweep%0d/%0d", a, b), 8'(a / b), 4'(a % b), 1'b0, 8, -1);
                    chk($sformatf("sweep%0d/%0d.identity", a, b),
                        int'(quotient) * b + int'(remainder), a);
                    chk($sformatf("sweep%0d/%0d.rem_lt_div", a, b),
                        {31'd0, (int'(remainder) < b)}, 32'd1);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
